// File: rtl/flag_pkg.sv
// Shared flag-unit constants, the flag-vector type and the ALU flag decode helper.
package flag_pkg;

  localparam int unsigned FLAG_W = 4;
  localparam int unsigned WORD_W = 16;

  localparam int unsigned FL_Z = 0;
  localparam int unsigned FL_N = 1;
  localparam int unsigned FL_C = 2;
  localparam int unsigned FL_V = 3;

  typedef logic [FLAG_W-1:0] flag_vec_t;

  function automatic flag_vec_t alu_flags(input logic [WORD_W-1:0] res,
                                          input logic cy,
                                          input logic ov);
    flag_vec_t f;
    f       = {FLAG_W{1'b0}};
    f[FL_Z] = (res == {WORD_W{1'b0}});
    f[FL_N] = res[WORD_W-1];
    f[FL_C] = cy;
    f[FL_V] = ov;
    return f;
  endfunction

endpackage

// File: rtl/flag_unit_if.sv
// Bundle of ALU-result, flag-edit, stack-control and FLAGS-register signals of flag_unit.
interface flag_unit_if;
  import flag_pkg::*;

  logic              res_valid;
  logic [WORD_W-1:0] res;
  logic              cy_in;
  logic              ov_in;
  logic              fl_set;
  logic              fl_clr;
  logic [1:0]        fl_sel;
  logic              push;
  logic              pop;
  logic              flags_en;
  logic [WORD_W-1:0] flags_out;
  logic              stk_full;
  logic              stk_empty;
  logic              stk_err;

  modport master (
    output res_valid, res, cy_in, ov_in, fl_set, fl_clr, fl_sel, push, pop,
    input  flags_en, flags_out, stk_full, stk_empty, stk_err
  );

  modport slave (
    input  res_valid, res, cy_in, ov_in, fl_set, fl_clr, fl_sel, push, pop,
    output flags_en, flags_out, stk_full, stk_empty, stk_err
  );

endinterface

// File: rtl/flag_stack.sv
// LIFO of saved flag vectors: storage, stack pointer, full/empty and error detection.
module flag_stack
  import flag_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  flag_vec_t din,
  output flag_vec_t top,
  output logic      pop_ok,
  output logic      full,
  output logic      empty,
  output logic      err
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SPW-1:0] sp_r;
  flag_vec_t      mem_r [DEPTH];
  logic           err_r;
  logic           push_ok_s;
  logic           err_s;
  logic [AW-1:0]  top_idx_s;
  logic [AW-1:0]  wr_idx_s;

  assign full      = (sp_r == SPW'(DEPTH));
  assign empty     = (sp_r == {SPW{1'b0}});
  assign top_idx_s = AW'(sp_r - SPW'(1));
  assign wr_idx_s  = AW'(sp_r);
  assign top       = empty ? {FLAG_W{1'b0}} : mem_r[top_idx_s];
  assign err       = err_r;

  // Simultaneous push and pop cancel each other; out-of-range requests only flag an error.
  always_comb begin
    push_ok_s = push & ~pop & ~full;
    pop_ok    = pop & ~push & ~empty;
    err_s     = (push & pop) | (push & ~pop & full) | (pop & ~push & empty);
  end

  // Stack pointer, storage and error pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_r  <= {SPW{1'b0}};
      err_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {FLAG_W{1'b0}};
      end
    end else begin
      err_r <= err_s;
      if (push_ok_s) begin
        mem_r[wr_idx_s] <= din;
        sp_r            <= sp_r + SPW'(1);
      end else if (pop_ok) begin
        sp_r <= sp_r - SPW'(1);
      end else begin
        sp_r <= sp_r;
      end
    end
  end

endmodule

// File: rtl/flag_unit.sv
// Flag shadow register feeding FLAGS.in, with an optional save/restore stack.
// Stack is built only when FLAG_UNIT_STACK_EN is defined.
module flag_unit #(
  parameter int STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  flag_unit_if.slave bus
);
  import flag_pkg::*;

  flag_vec_t cur_r;
  flag_vec_t next_cur_s;
  flag_vec_t stk_top_s;
  logic      flags_en_r;
  logic      wr_s;
  logic      pop_ok_s;
  logic      pop_blk_s;

`ifdef FLAG_UNIT_STACK_EN
  logic stk_full_s;
  logic stk_empty_s;
  logic stk_err_s;

  flag_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .clk    (clk),
    .rst    (rst),
    .push   (bus.push),
    .pop    (bus.pop),
    .din    (cur_r),
    .top    (stk_top_s),
    .pop_ok (pop_ok_s),
    .full   (stk_full_s),
    .empty  (stk_empty_s),
    .err    (stk_err_s)
  );

  // A lone pop owns the cycle even when it fails on an empty stack.
  assign pop_blk_s     = bus.pop & ~bus.push;
  assign bus.stk_full  = stk_full_s;
  assign bus.stk_empty = stk_empty_s;
  assign bus.stk_err   = stk_err_s;
`else
  logic unused_stk_s;

  assign unused_stk_s  = bus.push ^ bus.pop;
  assign stk_top_s     = {FLAG_W{1'b0}};
  assign pop_ok_s      = 1'b0;
  assign pop_blk_s     = 1'b0;
  assign bus.stk_full  = 1'b0;
  assign bus.stk_empty = 1'b1;
  assign bus.stk_err   = 1'b0;
`endif

  // Next flag value by priority: pop restore, ALU result, single-flag edit.
  always_comb begin
    next_cur_s = cur_r;
    wr_s       = 1'b0;
    if (pop_blk_s) begin
      if (pop_ok_s) begin
        next_cur_s = stk_top_s;
        wr_s       = 1'b1;
      end else begin
        next_cur_s = cur_r;
      end
    end else if (bus.res_valid) begin
      next_cur_s = alu_flags(bus.res, bus.cy_in, bus.ov_in);
      wr_s       = 1'b1;
    end else if (bus.fl_set ^ bus.fl_clr) begin
      next_cur_s[bus.fl_sel] = bus.fl_set;
      wr_s                   = 1'b1;
    end else begin
      next_cur_s = cur_r;
    end
  end

  // Shadow flags and the FLAGS write strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_r      <= {FLAG_W{1'b0}};
      flags_en_r <= 1'b0;
    end else begin
      cur_r      <= next_cur_s;
      flags_en_r <= wr_s;
    end
  end

  assign bus.flags_en  = flags_en_r;
  assign bus.flags_out = {{(WORD_W - FLAG_W){1'b0}}, cur_r};

endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit: directed table, stack corner sequences, random vs queue model.
module tb_flag_unit;

  localparam int DEPTH = 4;
`ifdef FLAG_UNIT_STACK_EN
  localparam bit HAS_STK = 1'b1;
`else
  localparam bit HAS_STK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  flag_unit_if bus();
  flag_unit #(.STACK_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;

  logic [3:0] m_cur = 4'h0;
  logic [3:0] m_stk[$];
  logic       m_en  = 1'b0;
  logic       m_err = 1'b0;

  typedef struct {
    logic        r;
    logic        rv;
    logic [15:0] res;
    logic        cy;
    logic        ov;
    logic        set;
    logic        clr;
    logic [1:0]  sel;
    logic [15:0] exp_out;
    logic        exp_en;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: flags are {V,C,N,Z}; the stack is a plain queue whose back is the top.
  function automatic void model_step();
    logic [3:0] nxt;
    logic wr, err, blk;
    nxt = m_cur; wr = 1'b0; err = 1'b0; blk = 1'b0;
    if (rst) begin
      m_cur = 4'h0; m_stk.delete(); m_en = 1'b0; m_err = 1'b0;
      return;
    end
    if (HAS_STK) begin
      if (bus.push && bus.pop) err = 1'b1;
      else if (bus.pop) begin
        blk = 1'b1;
        if (m_stk.size() == 0) err = 1'b1;
        else begin nxt = m_stk.pop_back(); wr = 1'b1; end
      end else if (bus.push) begin
        if (m_stk.size() == DEPTH) err = 1'b1;
        else m_stk.push_back(m_cur);
      end
    end
    if (!blk) begin
      if (bus.res_valid) begin
        nxt = {bus.ov_in, bus.cy_in, bus.res[15], (bus.res == 16'h0000)};
        wr  = 1'b1;
      end else if (bus.fl_set != bus.fl_clr) begin
        nxt[bus.fl_sel] = bus.fl_set;
        wr = 1'b1;
      end
    end
    m_cur = nxt; m_en = wr; m_err = err;
  endfunction

  task automatic drive(input logic r, input logic rv, input logic [15:0] res, input logic cy,
                       input logic ov, input logic set, input logic clr, input logic [1:0] sel,
                       input logic push, input logic pop);
    rst = r; bus.res_valid = rv; bus.res = res; bus.cy_in = cy; bus.ov_in = ov;
    bus.fl_set = set; bus.fl_clr = clr; bus.fl_sel = sel; bus.push = push; bus.pop = pop;
  endtask

  task automatic cyc(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk({tag, ".out"},   bus.flags_out,         {12'h000, m_cur});
    chk({tag, ".en"},    {15'h0, bus.flags_en},  {15'h0, m_en});
    chk({tag, ".err"},   {15'h0, bus.stk_err},   {15'h0, m_err});
    chk({tag, ".full"},  {15'h0, bus.stk_full},  {15'h0, (m_stk.size() == DEPTH)});
    chk({tag, ".empty"}, {15'h0, bus.stk_empty}, {15'h0, (m_stk.size() == 0)});
  endtask

  task automatic op(input string tag, input logic r, input logic rv, input logic [15:0] res,
                    input logic cy, input logic ov, input logic set, input logic clr,
                    input logic [1:0] sel, input logic push, input logic pop);
    drive(r, rv, res, cy, ov, set, clr, sel, push, pop);
    cyc(tag);
  endtask

  initial begin
    //          r     rv    res       cy    ov    set   clr   sel    exp_out   en
    tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0005, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0005, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 16'h8001, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h000A, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 16'h000E, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 16'h000E, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 16'h0006, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 16'h0000, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0001, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0000, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h000E, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h000E, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0};

    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].r, tbl[i].rv, tbl[i].res, tbl[i].cy, tbl[i].ov,
            tbl[i].set, tbl[i].clr, tbl[i].sel, 1'b0, 1'b0);
      cyc($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.exp_out", i), bus.flags_out, tbl[i].exp_out);
      chk($sformatf("tbl%0d.exp_en", i), {15'h0, bus.flags_en}, {15'h0, tbl[i].exp_en});
    end

`ifdef FLAG_UNIT_STACK_EN
    op("s_rst", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    op("s_c1",  1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    op("s_p1",  1'b0, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    op("s_p2",  1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    op("s_p3",  1'b0, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    op("s_p4",  1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    chk("full_after4", {15'h0, bus.stk_full}, 16'h0001);
    op("s_p5",  1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    chk("ovf_err", {15'h0, bus.stk_err}, 16'h0001);
    op("s_idle", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("ovf_err_pulse", {15'h0, bus.stk_err}, 16'h0000);
    op("s_o1", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("pop1", bus.flags_out, 16'h0008);
    op("s_o2", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("pop2", bus.flags_out, 16'h0004);
    op("s_o3", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("pop3", bus.flags_out, 16'h0002);
    op("s_o4", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("pop4", bus.flags_out, 16'h0001);
    chk("empty_after4", {15'h0, bus.stk_empty}, 16'h0001);
    op("s_udf", 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("udf_err", {15'h0, bus.stk_err}, 16'h0001);
    chk("udf_en", {15'h0, bus.flags_en}, 16'h0000);
    chk("udf_out", bus.flags_out, 16'h0001);
    op("s_idle2", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("udf_err_pulse", {15'h0, bus.stk_err}, 16'h0000);
    op("s_a",   1'b0, 1'b1, 16'h8001, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    op("s_pa",  1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    op("s_5",   1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    op("s_prv", 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("pop_beats_rv", bus.flags_out, 16'h000A);
    op("s_q1",  1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    op("s_q2",  1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    op("s_cf",  1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1);
    chk("conflict_err", {15'h0, bus.stk_err}, 16'h0001);
    chk("conflict_clr", bus.flags_out, 16'h0008);
    op("s_cfp", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("conflict_keeps_top", bus.flags_out, 16'h000A);
    op("s_rst2", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    chk("rst_empty", {15'h0, bus.stk_empty}, 16'h0001);
    chk("rst_out", bus.flags_out, 16'h0000);
`else
    op("d_rst", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    op("d_push", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    chk("nostk_push_err", {15'h0, bus.stk_err}, 16'h0000);
    chk("nostk_push_en", {15'h0, bus.flags_en}, 16'h0000);
    op("d_poprv", 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("nostk_rv_applies", bus.flags_out, 16'h0001);
    op("d_pop", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("nostk_pop_en", {15'h0, bus.flags_en}, 16'h0000);
    chk("nostk_pop_err", {15'h0, bus.stk_err}, 16'h0000);
    chk("nostk_empty", {15'h0, bus.stk_empty}, 16'h0001);
`endif

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 39) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom),
            1'($urandom), 1'($urandom),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
            2'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      cyc($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/flag_unit.md
FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 Parameter: STACK_DEPTH, default 4, number of flag-stack entries (2..8).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 res_valid  input  1  ALU result valid this cycle.
REQ-005 res  input  16  ALU result word.
REQ-006 cy_in  input  1  ALU carry-out.
REQ-007 ov_in  input  1  ALU signed overflow.
REQ-008 fl_set  input  1  set the flag selected by fl_sel.
REQ-009 fl_clr  input  1  clear the flag selected by fl_sel.
REQ-010 fl_sel  input  2  flag index: 0=Z, 1=N, 2=C, 3=V.
REQ-011 push  input  1  save current flags to the stack.
REQ-012 pop  input  1  restore flags from the stack.
REQ-013 flags_en  output  1  write enable for the downstream FLAGS register.
REQ-014 flags_out  output  16  flag word for FLAGS.in; bits 3:0 = {V,C,N,Z}, bits 15:4 = 0.
REQ-015 stk_full  output  1  stack holds STACK_DEPTH entries.
REQ-016 stk_empty  output  1  stack holds 0 entries.
REQ-017 stk_err  output  1  one-cycle pulse on overflow, underflow or a push/pop conflict.

Function
REQ-018 The block SHALL keep a 4-bit shadow register cur; flags_out[3:0] SHALL equal cur at all times.
REQ-019 res_valid SHALL load cur: Z=(res==0), N=res[15], C=cy_in, V=ov_in.
REQ-020 fl_set/fl_clr SHALL modify only cur[fl_sel]; if both are asserted, the bit SHALL be unchanged and no error SHALL be raised.
REQ-021 Per-cycle priority SHALL be, highest first: pop, res_valid, fl_set/fl_clr; lower-priority updates SHALL be dropped.
REQ-022 push SHALL write the pre-update cur to stack[sp] and increment sp.
REQ-023 pop SHALL load cur from stack[sp-1] and decrement sp.
REQ-024 Latency SHALL be one cycle: an event at edge t updates cur, and flags_en is high for exactly the cycle after t.
REQ-025 flags_en SHALL be registered and asserted only when cur was written (res_valid, fl_set xor fl_clr, or a successful pop).
REQ-026 push while stk_full SHALL leave the stack unchanged and pulse stk_err.
REQ-027 pop while stk_empty SHALL leave cur and the stack unchanged, assert no flags_en, and pulse stk_err.
REQ-028 push and pop in the same cycle SHALL cause no stack change and no pop restore, and SHALL pulse stk_err; res_valid/fl_set/fl_clr SHALL still apply.
REQ-029 stk_full and stk_empty SHALL be derived combinationally from sp; sp SHALL NOT wrap.

Reset
REQ-030 When rst is high at a clock edge, cur=0, sp=0, flags_en=0, stk_err=0, and all stack entries SHALL be set to 0.
REQ-031 Reset SHALL override all inputs in the same cycle, and a push/pop in progress SHALL be discarded.
REQ-032 After reset: flags_out=16'h0000, stk_empty=1, stk_full=0.

Configuration
REQ-033 Macro FLAG_UNIT_STACK_EN: when defined, the stack is implemented as specified above.
REQ-034 When FLAG_UNIT_STACK_EN is undefined, no stack storage SHALL exist; push/pop SHALL be ignored; stk_full=0, stk_empty=1, stk_err=0 constant.

Structure
REQ-035 Package flag_pkg SHALL hold the flag index constants (FL_Z=0, FL_N=1, FL_C=2, FL_V=3), FLAG_W=4, WORD_W=16, and the flag-vector typedef.
REQ-036 The stack SHALL be a sub-module, flag_stack (storage, sp, full/empty, error detection), instantiated only under FLAG_UNIT_STACK_EN.

Verification
REQ-037 Reset, then res_valid with res=16'h0000, cy_in=1, ov_in=0 -> next cycle flags_en=1, flags_out=16'h0005.
REQ-038 res_valid with res=16'h8001, cy_in=0, ov_in=1 -> flags_out=16'h000A; fl_set with fl_sel=2 -> flags_out=16'h000E.
REQ-039 push 4 times with cur=1,2,4,8, then a fifth push -> stk_full=1, stk_err pulses once; 4 pops -> flags_out 8,4,2,1, then stk_empty=1.
REQ-040 pop on an empty stack -> stk_err=1 for one cycle, flags_en=0, flags_out unchanged.
REQ-041 pop with res_valid (res=0) in the same cycle, stack top=4'hA -> flags_out=16'h000A.
REQ-042 rst asserted after 2 pushes -> stk_empty=1, flags_out=0; built without FLAG_UNIT_STACK_EN, push/pop -> no change, stk_err=0.
